// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle arithmetic/logic/shift ops plus an iterative
// shift-add multiplier, with a registered result and Z/N/C/V flags.
module alu_seq #(
  parameter int WIDTH  = 16,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [2:0]       alu_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic             z,
  output logic             n,
  output logic             c,
  output logic             v
);

  // state | meaning
  // IDLE  | ready for a new operation
  // BUSY  | multiplier stepping, one partial product per cycle
  // DONE  | result and flags presented until out_ready
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int CW = $clog2(WIDTH);

  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_SHL = 3'd3;
  localparam logic [2:0] OP_SHR = 3'd4;
  localparam logic [2:0] OP_AND = 3'd5;
  localparam logic [2:0] OP_OR  = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  state_t             state;
  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;

  logic [WIDTH:0]     sum_w;
  logic [WIDTH:0]     dif_w;
  logic [WIDTH:0]     shl_w;
  logic [WIDTH:0]     shr_w;
  logic [WIDTH-1:0]   res_c;
  logic               c_c;
  logic               v_c;
  logic [2*WIDTH-1:0] acc_nx;

  // Shifts run one bit wider so the last bit shifted out lands in the spare bit.
  always_comb begin
    sum_w = {1'b0, in1} + {1'b0, in2};
    dif_w = {1'b0, in1} - {1'b0, in2};
    shl_w = {1'b0, in1} << in2;
    shr_w = {in1, 1'b0} >> in2;
    res_c = '0;
    c_c   = 1'b0;
    v_c   = 1'b0;
    case (alu_op)
      OP_ADD: begin
        res_c = sum_w[WIDTH-1:0];
        c_c   = sum_w[WIDTH];
        v_c   = (in1[WIDTH-1] == in2[WIDTH-1]) && (sum_w[WIDTH-1] != in1[WIDTH-1]);
      end
      OP_SUB: begin
        res_c = dif_w[WIDTH-1:0];
        c_c   = dif_w[WIDTH];
        v_c   = (in1[WIDTH-1] != in2[WIDTH-1]) && (dif_w[WIDTH-1] != in1[WIDTH-1]);
      end
      OP_SHL: begin
        res_c = shl_w[WIDTH-1:0];
        c_c   = shl_w[WIDTH];
      end
      OP_SHR: begin
        res_c = shr_w[WIDTH:1];
        c_c   = shr_w[0];
      end
      OP_AND: res_c = in1 & in2;
      OP_OR:  res_c = in1 | in2;
      default: ;
    endcase
  end

  always_comb begin
    acc_nx = acc;
    if (mplier[0]) acc_nx = acc + mcand;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      alu_out   <= '0;
      z         <= 1'b1;
      n         <= 1'b0;
      c         <= 1'b0;
      v         <= 1'b0;
      count     <= '0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            if (MUL_EN && alu_op == OP_MUL) begin
              state  <= BUSY;
              count  <= '0;
              acc    <= '0;
              mcand  <= {{WIDTH{1'b0}}, in1};
              mplier <= in2;
            end else begin
              state     <= DONE;
              out_valid <= 1'b1;
              alu_out   <= res_c;
              z         <= (res_c == '0);
              n         <= res_c[WIDTH-1];
              c         <= c_c;
              v         <= v_c;
            end
          end
        end
        BUSY: begin
          if (count == CW'(WIDTH - 1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
            alu_out   <= acc_nx[WIDTH-1:0];
            z         <= (acc_nx[WIDTH-1:0] == '0);
            n         <= acc_nx[WIDTH-1];
            c         <= |acc_nx[2*WIDTH-1:WIDTH];
            v         <= 1'b0;
            count     <= '0;
          end else begin
            acc    <= acc_nx;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq (WIDTH=16): arithmetic reference model with a per-cycle
// compare process, directed corner cases and randomized transactions.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] in1 = '0;
  logic [15:0] in2 = '0;
  logic [2:0]  alu_op = '0;
  logic        in_ready, out_valid, z, n, c, v;
  logic [15:0] alu_out;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    logic [15:0] r;
    logic        c;
    logic        v;
    int          due;
  } exp_t;

  exp_t q[$];

  alu_seq #(.WIDTH(16), .MUL_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in1(in1), .in2(in2), .alu_op(alu_op), .out_valid(out_valid),
    .out_ready(out_ready), .alu_out(alu_out), .z(z), .n(n), .c(c), .v(v)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    longint ua, ub, sa, sb, r, s;
    exp_t e;
    ua = longint'(a);
    ub = longint'(b);
    sa = (ua >= 32768) ? ua - 65536 : ua;
    sb = (ub >= 32768) ? ub - 65536 : ub;
    r = 0;
    e.c = 1'b0;
    e.v = 1'b0;
    e.due = 0;
    case (op)
      3'd1: begin
        r = ua + ub; e.c = (r > 65535);
        s = sa + sb; e.v = (s > 32767) || (s < -32768);
      end
      3'd2: begin
        r = ua - ub; e.c = (ua < ub);
        s = sa - sb; e.v = (s > 32767) || (s < -32768);
      end
      3'd3: begin
        if (ub == 0) r = ua;
        else if (ub <= 16) begin r = ua << ub; e.c = ((ua >> (16 - ub)) & 1) != 0; end
      end
      3'd4: begin
        if (ub == 0) r = ua;
        else if (ub <= 16) begin r = ua >> ub; e.c = ((ua >> (ub - 1)) & 1) != 0; end
      end
      3'd5: r = ua & ub;
      3'd6: r = ua | ub;
      3'd7: begin r = ua * ub; e.c = (r >> 16) != 0; end
      default: r = 0;
    endcase
    e.r = r[15:0];
    return e;
  endfunction

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model advance: accept only when nothing is in flight, retire on handshake.
  always @(posedge clk) begin : mdl
    bit   acc_now, pop_now;
    exp_t e;
    if (rst_n) begin
      acc_now = in_valid && (q.size() == 0);
      pop_now = 1'b0;
      if (q.size() > 0) pop_now = (cyc >= q[0].due) && out_ready;
      cyc++;
      if (pop_now) void'(q.pop_front());
      if (acc_now) begin
        e = model(alu_op, in1, in2);
        e.due = cyc + ((alu_op == 3'd7) ? 16 : 0);
        q.push_back(e);
      end
    end
  end

  always @(negedge rst_n) q.delete();

  always @(negedge clk) begin : cmp
    bit ev;
    if (!rst_n) begin
      chk1("reset out_valid", out_valid, 1'b0);
      chk1("reset in_ready", in_ready, 1'b1);
      chk16("reset alu_out", alu_out, 16'h0000);
      chk1("reset z", z, 1'b1);
    end else begin
      ev = 1'b0;
      if (q.size() > 0) ev = (cyc >= q[0].due);
      chk1("in_ready", in_ready, q.size() == 0);
      chk1("out_valid", out_valid, ev);
      if (ev) begin
        chk16("alu_out", alu_out, q[0].r);
        chk1("flag c", c, q[0].c);
        chk1("flag v", v, q[0].v);
        chk1("flag z", z, q[0].r == 16'h0000);
        chk1("flag n", n, q[0].r[15]);
      end
    end
  end

  task automatic send(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    int k = 0;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    while (q.size() != 0 && k < 60) begin @(posedge clk); #1; k++; end
    chki("idle before send (queue depth)", q.size(), 0);
    in_valid = 1'b1; alu_op = op; in1 = a; in2 = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in1 = 16'($urandom); in2 = 16'($urandom); alu_op = 3'($urandom);
  endtask

  task automatic directed(input string nm, input logic [2:0] op, input logic [15:0] a,
                          input logic [15:0] b, input logic [15:0] er, input logic ec,
                          input logic evf, input int elat);
    int lat = 1;
    send(op, a, b);
    out_ready = 1'b0;
    while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    chki({nm, " latency"}, lat, elat);
    chk16({nm, " result"}, alu_out, er);
    chk1({nm, " c"}, c, ec);
    chk1({nm, " v"}, v, evf);
    chk1({nm, " z"}, z, er == 16'h0000);
    chk1({nm, " n"}, n, er[15]);
    out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    exp_t m;
    logic [2:0]  op;
    logic [15:0] a, b;
    int k;

    m = model(3'd1, 16'hFFFF, 16'h0001);
    chk16("model add wrap", m.r, 16'h0000); chk1("model add wrap c", m.c, 1'b1);
    m = model(3'd1, 16'h7FFF, 16'h0001);
    chk16("model add ovf", m.r, 16'h8000); chk1("model add ovf v", m.v, 1'b1);
    m = model(3'd2, 16'h0003, 16'h0005);
    chk16("model sub", m.r, 16'hFFFE); chk1("model sub borrow", m.c, 1'b1);
    m = model(3'd3, 16'h8001, 16'h0001);
    chk16("model shl", m.r, 16'h0002); chk1("model shl c", m.c, 1'b1);
    m = model(3'd7, 16'h0100, 16'h0100);
    chk16("model mul", m.r, 16'h0000); chk1("model mul c", m.c, 1'b1);

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    directed("add ffff+1", 3'd1, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1);
    directed("add 7fff+1", 3'd1, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1);
    directed("sub 3-5",    3'd2, 16'h0003, 16'h0005, 16'hFFFE, 1'b1, 1'b0, 1);
    directed("sub 5-5",    3'd2, 16'h0005, 16'h0005, 16'h0000, 1'b0, 1'b0, 1);
    directed("shl 8001<<1", 3'd3, 16'h8001, 16'h0001, 16'h0002, 1'b1, 1'b0, 1);
    directed("shr 00f0>>16", 3'd4, 16'h00F0, 16'd16, 16'h0000, 1'b0, 1'b0, 1);
    directed("shl by 0",   3'd3, 16'h1234, 16'h0000, 16'h1234, 1'b0, 1'b0, 1);
    directed("shl by 16",  3'd3, 16'h0001, 16'd16, 16'h0000, 1'b1, 1'b0, 1);
    directed("nop",        3'd0, 16'h1234, 16'h5678, 16'h0000, 1'b0, 1'b0, 1);
    directed("mul 100*100", 3'd7, 16'h0100, 16'h0100, 16'h0000, 1'b1, 1'b0, 17);
    directed("mul 7*6",    3'd7, 16'h0007, 16'h0006, 16'd42, 1'b0, 1'b0, 17);

    // Backpressure with a competing request that must be ignored.
    send(3'd1, 16'd2, 16'd2);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; alu_op = 3'd2; in1 = 16'd9; in2 = 16'd1;
      @(posedge clk); #1;
      chk16("backpressure alu_out", alu_out, 16'd4);
      chk1("backpressure in_ready", in_ready, 1'b0);
      chk1("backpressure out_valid", out_valid, 1'b1);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk1("release in_ready", in_ready, 1'b1);
    chk1("release out_valid", out_valid, 1'b0);

    // Reset in the middle of a multiply.
    send(3'd7, 16'd3, 16'd5);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk1("mid-mul reset out_valid", out_valid, 1'b0);
    chk1("mid-mul reset in_ready", in_ready, 1'b1);
    chk16("mid-mul reset alu_out", alu_out, 16'h0000);
    chk1("mid-mul reset z", z, 1'b1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (25) @(posedge clk);
    #1 chk1("no stale result after reset", out_valid, 1'b0);

    for (int i = 0; i < 300; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = 16'($urandom);
      b  = 16'($urandom);
      case ($urandom_range(0, 7))
        0: a = 16'hFFFF;
        1: b = 16'h0000;
        2: a = 16'h8000;
        default: ;
      endcase
      if (op == 3'd3 || op == 3'd4) b = 16'($urandom_range(0, 20));
      send(op, a, b);
      k = 0;
      while (q.size() != 0 && k < 80) begin
        out_ready = 1'($urandom_range(0, 1));
        in_valid  = 1'($urandom_range(0, 1));
        in1 = 16'($urandom); in2 = 16'($urandom); alu_op = 3'($urandom);
        @(posedge clk); #1;
        k++;
      end
      in_valid = 1'b0;
      chki("random drain (queue depth)", q.size(), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
